ipg_msg_asm: RTL



---
 rtl/ipg_pkg.sv | 31 +++
 rtl/ipg_bit_packer.sv | 36 +++
 rtl/ipg_msg_asm.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ipg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipg_pkg
// Description : Shared types and constants for the IPG message assembler.
//               Holds the assembler state encoding, message-type values and
//               the default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ipg_pkg;

  // Default widths of the fragment bus and of the message fields
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_HDR_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH     = 64;
  localparam int DEF_PAYLOAD_WIDTH  = 512;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Message type, carried in header bit 0
  localparam logic MSG_READ  = 1'b0;
  localparam logic MSG_WRITE = 1'b1;

  // Assembly state, named after the field currently being filled
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_ADDR    = 2'd2,
    ST_PAYLOAD = 2'd3
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/ipg_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : ipg_bit_packer
// Description : Appends the low 'len' bits of a fragment to the assembly
//               buffer at bit position 'fill_in'. Bits landing beyond the
//               buffer width fall off the top. The new fill is returned
//               unclamped so the caller can detect overshoot.
// Revision    : 1.0 - initial release
// ============================================================================
module ipg_bit_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_WIDTH  = 584,
  parameter int FILL_WIDTH = 10,
  parameter int LEN_WIDTH  = 7
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [BUF_WIDTH-1:0]  buf_in,
  input  logic [FILL_WIDTH-1:0] fill_in,
  output logic [BUF_WIDTH-1:0]  buf_out,
  output logic [FILL_WIDTH-1:0] fill_out
);

  logic [DATA_WIDTH-1:0] w_mask;
  logic [BUF_WIDTH-1:0]  w_ext;

  // Keep only the valid low bits; a shift of DATA_WIDTH yields a full mask
  assign w_mask = ~({DATA_WIDTH{1'b1}} << len);
  assign w_ext  = {{(BUF_WIDTH-DATA_WIDTH){1'b0}}, data & w_mask};

  // Buffer bits above fill are always zero, so OR-ing places the fragment
  assign buf_out  = buf_in | (w_ext << fill_in);
  assign fill_out = fill_in + FILL_WIDTH'(len);

endmodule
`default_nettype wire

// File: rtl/ipg_msg_asm.sv
`default_nettype none
// ============================================================================
// Module      : ipg_msg_asm
// Description : Assembles LSB-first IPG fragments into header/address/payload
//               messages, presents them on a one-deep valid/ready output
//               register, and flags timeout, overflow and truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module ipg_msg_asm
  import ipg_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int HDR_WIDTH      = DEF_HDR_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int PAYLOAD_WIDTH  = DEF_PAYLOAD_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_ipg_valid,
  input  logic [DATA_WIDTH-1:0]        rx_ipg_data,
  input  logic [$clog2(DATA_WIDTH):0]  rx_len,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [HDR_WIDTH-1:0]         m_hdr,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic [PAYLOAD_WIDTH-1:0]     m_payload,
  output logic                         m_is_write,
  output logic                         err_timeout,
  output logic                         err_ovf,
  output logic                         err_trunc,
  output logic [15:0]                  drop_cnt
);

  localparam int LEN_W     = $clog2(DATA_WIDTH) + 1;
  localparam int READ_LEN  = HDR_WIDTH + ADDR_WIDTH;
  localparam int WRITE_LEN = READ_LEN + PAYLOAD_WIDTH;
  localparam int BUF_W     = WRITE_LEN;
  localparam int FILL_W    = $clog2(BUF_W + DATA_WIDTH + 1);
  localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

  asm_state_t        r_state;
  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_idle_cnt;

  logic [LEN_W-1:0]  w_len_clamp;
  logic [LEN_W-1:0]  w_len_eff;
  logic [BUF_W-1:0]  w_buf_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [FILL_W-1:0] w_target;
  logic              w_accept;
  logic              w_is_wr;
  logic              w_done;
  logic              w_trunc;

  // Oversized lengths clamp to the bus width, then round down to whole bytes
  assign w_len_clamp = (rx_len > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : rx_len;
  assign w_len_eff   = {w_len_clamp[LEN_W-1:3], 3'b000};
  assign w_accept    = rx_ipg_valid && (rx_len != '0);

  ipg_bit_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_WIDTH  (BUF_W),
    .FILL_WIDTH (FILL_W),
    .LEN_WIDTH  (LEN_W)
  ) u_packer (
    .data     (rx_ipg_data),
    .len      (w_len_eff),
    .buf_in   (r_buf),
    .fill_in  (r_fill),
    .buf_out  (w_buf_next),
    .fill_out (w_fill_next)
  );

  // Header bit 0 picks the target; before any bits arrive it reads as 0,
  // which gives the short target and cannot complete with zero fill.
  assign w_is_wr  = (w_buf_next[0] == MSG_WRITE);
  assign w_target = w_is_wr ? FILL_W'(WRITE_LEN) : FILL_W'(READ_LEN);
  assign w_done   = w_accept && (w_fill_next >= w_target);
  assign w_trunc  = w_done && (w_fill_next > w_target);

  // Assembly FSM, idle timer and output register with registered error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_fill      <= '0;
      r_idle_cnt  <= '0;
      m_valid     <= 1'b0;
      m_hdr       <= '0;
      m_addr      <= '0;
      m_payload   <= '0;
      m_is_write  <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      err_trunc   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      err_trunc   <= 1'b0;

      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (w_accept) begin
        r_idle_cnt <= '0;
        if (w_done) begin
          r_state   <= ST_IDLE;
          r_buf     <= '0;
          r_fill    <= '0;
          err_trunc <= w_trunc;
          // Free register, or one being emptied this edge, takes the message
          if (!m_valid || m_ready) begin
            m_valid    <= 1'b1;
            m_hdr      <= w_buf_next[HDR_WIDTH-1:0];
            m_addr     <= w_buf_next[HDR_WIDTH +: ADDR_WIDTH];
            m_payload  <= w_is_wr ? w_buf_next[READ_LEN +: PAYLOAD_WIDTH] : '0;
            m_is_write <= w_is_wr;
          end else begin
            err_ovf <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
          end
        end else begin
          r_buf  <= w_buf_next;
          r_fill <= w_fill_next;
          // A write past the address boundary is the only way to get here
          if (w_fill_next >= FILL_W'(READ_LEN)) begin
            r_state <= ST_PAYLOAD;
          end else if (w_fill_next >= FILL_W'(HDR_WIDTH)) begin
            r_state <= ST_ADDR;
          end else begin
            r_state <= ST_HDR;
          end
        end
      end else if (r_state != ST_IDLE) begin
        if (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          r_state     <= ST_IDLE;
          r_buf       <= '0;
          r_fill      <= '0;
          r_idle_cnt  <= '0;
          err_timeout <= 1'b1;
        end else begin
          r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire
